// File: rtl/templatized_alu_pkg.sv
// Shared definitions for the templatized ALU and its request scheduler.
package templatized_alu_pkg;

  localparam logic [2:0] OPCODE_XOR           = 3'b000;
  localparam logic [2:0] OPCODE_SHIFTLEFT     = 3'b001;
  localparam logic [2:0] OPCODE_SHIFTRIGHT    = 3'b010;
  localparam logic [2:0] OPCODE_ROTATIONLEFT  = 3'b011;
  localparam logic [2:0] OPCODE_ROTATIONRIGHT = 3'b100;
  // Drives every ALU group enable low; used whenever nothing is executing.
  localparam logic [2:0] OPCODE_NOP           = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Opcodes above the rotate-right encoding have no ALU group behind them.
  function automatic logic opcode_is_legal(input logic [2:0] op_code);
    return (op_code <= OPCODE_ROTATIONRIGHT);
  endfunction

endpackage

// File: rtl/templatized_alu_control.sv
// ALU group decode: en[1] selects the xor group, en[0] the shift/rotate group.
module templatized_alu_control
  import templatized_alu_pkg::*;
(
  input  logic [2:0] op_code,
  output logic [1:0] en
);

  // One-hot group enable, all-zero for illegal opcodes.
  always_comb begin
    en = 2'b00;
    if (opcode_is_legal(op_code)) begin
      en = (op_code == OPCODE_XOR) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/templatized_alu_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr, cyclically.
module templatized_alu_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   idx;

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/templatized_alu_scheduler.sv
// Shares one templatized ALU among NUM_REQ requesters with round-robin issue.
//
//  state | meaning
//  IDLE  | waiting for a request; grant is combinational on req_ready
//  EXEC  | ALU inputs held, down-counter running the group latency
//  RESP  | response held on rsp_* until rsp_ready
module templatized_alu_scheduler
  import templatized_alu_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int LAT_XOR   = 1,
  parameter int LAT_SHIFT = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][2:0]           req_op_code,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_b,
  output logic [2:0]                        alu_op_code,
  output logic [WIDTH-1:0]                  alu_a,
  output logic [WIDTH-1:0]                  alu_b,
  input  logic [WIDTH-1:0]                  alu_result,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [WIDTH-1:0]                  rsp_result,
  output logic                              rsp_err
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int LAT_MAX = (LAT_XOR > LAT_SHIFT) ? LAT_XOR : LAT_SHIFT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [2:0]        win_op;
  logic [1:0]        grp_en;
  logic              grant;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_exec;

  templatized_alu_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign win_op = req_op_code[gnt_idx];

  templatized_alu_control u_ctl (
    .op_code (win_op),
    .en      (grp_en)
  );

  assign next_ptr  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  // Guarding with <= 1 keeps a corrupted zero count from stalling in EXEC.
  assign last_exec = (cnt_q <= CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, grant and response-valid decode.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          grant     = 1'b1;
          req_ready = gnt;
          state_d   = (grp_en == 2'b00) ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (last_exec) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on grant, hold ALU inputs through EXEC, latch the result at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      alu_op_code <= OPCODE_NOP;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
    end else if (grant) begin
      rr_ptr_q <= next_ptr;
      rsp_id   <= gnt_idx;
      if (grp_en == 2'b00) begin
        rsp_err    <= 1'b1;
        rsp_result <= '0;
      end else begin
        rsp_err     <= 1'b0;
        alu_op_code <= win_op;
        alu_a       <= req_a[gnt_idx];
        alu_b       <= req_b[gnt_idx];
        cnt_q       <= grp_en[1] ? CNT_W'(LAT_XOR) : CNT_W'(LAT_SHIFT);
      end
    end else if (state_q == EXEC) begin
      if (last_exec) begin
        rsp_result  <= alu_result;
        cnt_q       <= '0;
        alu_op_code <= OPCODE_NOP;
        alu_a       <= '0;
        alu_b       <= '0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/templatized_alu_scheduler.md
# templatized_alu_scheduler

Round-robin scheduler that shares one templatized ALU among `NUM_REQ` requesters. It arbitrates valid/ready requests and issues one operation at a time to the ALU. It holds ALU inputs stable for the group-specific latency, then returns the tagged result through a valid/ready response port. It sits between the requester ports and the ALU datapath, and it is the only driver of the ALU's `op_code` and operands.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 32: operand/result width.
- `LAT_XOR`, 1: EXEC cycles for the xor group, ≥1.
- `LAT_SHIFT`, 2: EXEC cycles for the shift/rotate group, ≥1.

Ports:
- `clk`  in  1  clock; one clock domain, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant; a request is accepted when valid&ready.
- `req_op_code`  in  NUM_REQ×3  per-requester opcode.
- `req_a`, `req_b`  in  NUM_REQ×WIDTH  per-requester operands.
- `alu_op_code`  out  3  to ALU, registered.
- `alu_a`, `alu_b`  out  WIDTH  to ALU, registered.
- `alu_result`  in  WIDTH  from ALU; valid in the final EXEC cycle.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  $clog2(NUM_REQ)  requester index of the response.
- `rsp_result`  out  WIDTH  result; 0 when `rsp_err`.
- `rsp_err`  out  1  opcode was illegal (3'b101–3'b111).

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` is set, grant the first requester at or after `rr_ptr`, cyclically.
  - Assert `req_ready` only for the winner, combinationally, in IDLE only.
  - Capture the winner's opcode, operands and id.
  - Set `rr_ptr` = winner+1 (mod NUM_REQ).
- **Decode on grant:**
  - Xor group (000) → latency `LAT_XOR`.
  - Shift/rotate group (001–100) → latency `LAT_SHIFT`.
  - Illegal opcode → go to RESP directly with `rsp_err`=1 and `rsp_result`=0; nothing is issued to the ALU.
- **EXEC:**
  - `alu_op_code`/`alu_a`/`alu_b` hold the captured values.
  - Down-counter loads the latency and decrements each cycle.
  - On the final cycle, register `alu_result` into `rsp_result` and go to RESP.
- **RESP:**
  - `rsp_valid`=1; `rsp_id`/`rsp_result`/`rsp_err` stay stable until `rsp_ready`.
  - On the handshake, go to IDLE.
- **Outside EXEC:** `alu_op_code`=3'b111 (all ALU groups disabled) and `alu_a`=`alu_b`=0.
- **Reset values:**
  - State IDLE, `rr_ptr`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0.
  - `alu_op_code`=3'b111, `alu_a`=`alu_b`=0, counter 0.
- **Reset mid-operation:** the in-flight op is dropped with no response, and `rr_ptr` returns to 0.
- **Request changes:** requesters may drop or change `req_valid` before a grant; the scheduler samples only in IDLE.

## Timing
- Grant at cycle T. ALU inputs are valid T+1 … T+L, where L is the group latency.
- Result is captured at the end of T+L; `rsp_valid` rises at T+L+1.
- Illegal opcode: `rsp_valid` at T+1.
- Response handshake at cycle R → IDLE at R+1 → earliest next grant at R+1.
- Back-to-back xor with `rsp_ready`=1: one op every 3 cycles.
- Counter width is $clog2(max(LAT_XOR, LAT_SHIFT)+1).
- Simultaneous valids resolve only by `rr_ptr`; no requester waits more than NUM_REQ−1 grants.

## Structure
- Shared package `templatized_alu_pkg` holds:
  - opcode constants (`OPCODE_XOR` … `OPCODE_ROTATIONRIGHT`, `OPCODE_NOP`=3'b111);
  - `sched_state_e`;
  - function `opcode_is_legal`.
- Group decode reuses existing `templatized_alu_control`: `en`=2'b10 → xor latency, 2'b01 → shift latency, 2'b00 → illegal.
- One sub-module, `templatized_alu_rr_arbiter` (NUM_REQ parameter), with:
  - inputs `req` and `ptr`;
  - outputs one-hot `gnt` and `gnt_idx`.

## Test plan
- **Reset:** hold `rst` for 3 cycles, including once mid-EXEC → all outputs at reset values, `alu_op_code`=3'b111, no `rsp_valid` afterwards.
- **Single xor:** req0, op 000, a=0xF0F0_0000, b=0x0FF0_0000 (ALU model returns a^b) → `rsp_valid` at T+2, result 0xFF00_0000, id 0, err 0.
- **Shift with backpressure:** req2, op 001, `LAT_SHIFT`=2, `rsp_ready` low for 4 cycles → `rsp_valid` at T+3, response stable until the handshake, `alu_op_code` returns to 111 at T+3.
- **Fairness:** all 4 requesters valid continuously → grant order 0,1,2,3,0, each id returned exactly once per round.
- **Illegal opcode:** req1, op 110 → `rsp_valid` at T+1, err 1, result 0, `alu_op_code` never leaves 111.
